// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: glyph table,
// segment bit positions and "all off" patterns.
package seven_seg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high {dp,g,f,e,d,c,b,a}; dp is always clear in the table.
  localparam logic [7:0] SEG_GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam logic [7:0] SEG_OFF_AH = 8'h00;
  localparam logic [7:0] SEG_OFF_AL = 8'hFF;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex-to-segment decoder; output is active-high, polarity is
// applied by the parent.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg         = SEG_GLYPH[i_nib];
    o_seg[SEG_DP] = i_dp;
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit seven-segment driver with per-slot anode blanking.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [4*N_DIGITS-1:0]   i_hex,
  input  logic [N_DIGITS-1:0]     i_dp,
  input  logic [N_DIGITS-1:0]     i_digit_en,
  output logic [7:0]              o_sseg,
  output logic [N_DIGITS-1:0]     o_an,
  output logic                    o_frame_start
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]      r_cnt, w_cnt_d;
  logic [IDX_W-1:0]      r_idx, w_idx_d;
  logic [4*N_DIGITS-1:0] r_hex;
  logic [N_DIGITS-1:0]   r_dp, r_en;
  logic                  r_loaded;
  logic [7:0]            r_sseg, w_sseg_d;
  logic [N_DIGITS-1:0]   r_an, w_an_d;
  logic                  r_frame_start;

  logic                  w_wrap, w_last, w_load, w_blank;
  logic [N_DIGITS-1:0]   w_en_eff, w_sel;
  logic [3:0]            w_nib;
  logic [7:0]            w_seg_ah;

  assign w_wrap  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last  = (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_load  = w_wrap && w_last;
  // Nothing is displayed until the first shadow load after reset.
  assign w_blank = (r_cnt < CNT_W'(BLANK_CYC)) || !r_loaded;

  always_comb begin
    w_cnt_d = w_wrap ? '0 : r_cnt + CNT_W'(1);
    w_idx_d = r_idx;
    if (w_wrap) w_idx_d = w_last ? '0 : r_idx + IDX_W'(1);
  end

`ifdef SEVEN_SEG_LZB_EN
  // A zero digit without dp is suppressed while everything above it is dark.
  always_comb begin
    logic w_dark_above;
    w_en_eff     = r_en;
    w_dark_above = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
      if (w_dark_above && (r_hex[4*i +: 4] == 4'h0) && !r_dp[i]) w_en_eff[i] = 1'b0;
      w_dark_above = w_dark_above && !w_en_eff[i];
    end
  end
`else
  assign w_en_eff = r_en;
`endif

  assign w_nib = r_hex[{r_idx, 2'b00} +: 4];

  seven_seg_decode u_decode (
    .i_nib (w_nib),
    .i_dp  (r_dp[r_idx]),
    .o_seg (w_seg_ah)
  );

  always_comb begin
    w_sel        = '0;
    w_sel[r_idx] = 1'b1;
  end

  always_comb begin
    w_an_d   = AN_OFF;
    w_sseg_d = SEG_OFF;
    if (!w_blank) begin
      w_an_d = AN_ACTIVE_LOW ? ~w_sel : w_sel;
      if (w_en_eff[r_idx]) w_sseg_d = SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_hex         <= '0;
      r_dp          <= '0;
      r_en          <= '0;
      r_loaded      <= 1'b0;
      r_sseg        <= SEG_OFF;
      r_an          <= AN_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_d;
      r_idx         <= w_idx_d;
      r_sseg        <= w_sseg_d;
      r_an          <= w_an_d;
      r_frame_start <= w_load;
      if (w_load) begin
        r_hex    <= i_hex;
        r_dp     <= i_dp;
        r_en     <= i_digit_en;
        r_loaded <= 1'b1;
      end
    end
  end

  assign o_sseg        = r_sseg;
  assign o_an          = r_an;
  assign o_frame_start = r_frame_start;

endmodule
